// File: rtl/pcs_rx_sync_monitor.sv
// pcs_rx_sync_monitor
// 64b/66b RX block-lock state machine with configurable thresholds, a
// post-slip settle timer, a hi_ber monitor and a saturating errored-block
// counter. All outputs come straight from flops.
//
// Handshake: i_header is consumed on every clock where i_header_valid=1 and
// the block is in TEST_SH; there is no back-pressure, and headers that arrive
// during SLIP_WAIT are dropped.
module pcs_rx_sync_monitor #(
    parameter int unsigned LOCK_COUNT       = 64,
    parameter int unsigned BAD_LOCK_COUNT   = 16,
    parameter int unsigned SLIP_WAIT_CYCLES = 32,
    parameter int unsigned BER_WINDOW       = 31250,
    parameter int unsigned BER_THRESH       = 16,
    parameter int unsigned ERR_CNT_WIDTH    = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [1:0]               i_header,
    input  logic                     i_header_valid,
    input  logic                     i_clear_cnt,
    output logic                     o_slip,
    output logic                     o_block_lock,
    output logic                     o_hi_ber,
    output logic [ERR_CNT_WIDTH-1:0] o_errored_blocks
);

    localparam int unsigned SH_W   = $clog2(LOCK_COUNT + 1);
    localparam int unsigned BAD_W  = $clog2(BAD_LOCK_COUNT + 1);
    localparam int unsigned WAIT_W = $clog2(SLIP_WAIT_CYCLES + 1);
    localparam int unsigned TMR_W  = $clog2(BER_WINDOW + 1);
    localparam int unsigned BER_W  = $clog2(BER_THRESH + 1);

    typedef enum logic {
        ST_TEST_SH   = 1'b0,
        ST_SLIP_WAIT = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic                     lock_q, lock_d;
    logic                     slip_q, slip_d;
    logic                     hi_ber_q, hi_ber_d;
    logic [SH_W-1:0]          sh_cnt_q, sh_cnt_d;
    logic [BAD_W-1:0]         invld_q, invld_d;
    logic [WAIT_W-1:0]        wait_q, wait_d;
    logic [TMR_W-1:0]         timer_q, timer_d;
    logic [BER_W-1:0]         ber_cnt_q, ber_cnt_d;
    logic [ERR_CNT_WIDTH-1:0] err_q, err_d;

    logic                     hdr_bad;
    logic                     hdr_eval;
    logic                     bad_eval;
    logic [SH_W-1:0]          sh_nxt;
    logic [BAD_W-1:0]         invld_nxt;

    // Next-state logic for the lock FSM, BER monitor and errored counter.
    always_comb begin
        state_d   = state_q;
        lock_d    = lock_q;
        slip_d    = 1'b0;
        hi_ber_d  = hi_ber_q;
        sh_cnt_d  = sh_cnt_q;
        invld_d   = invld_q;
        wait_d    = wait_q;
        timer_d   = timer_q;
        ber_cnt_d = ber_cnt_q;
        err_d     = err_q;

        // 2'b00 and 2'b11 are the two illegal sync headers.
        hdr_bad   = (i_header[1] == i_header[0]);
        hdr_eval  = i_header_valid && (state_q == ST_TEST_SH);
        bad_eval  = hdr_eval && hdr_bad;
        sh_nxt    = sh_cnt_q + SH_W'(1);
        invld_nxt = invld_q + BAD_W'(hdr_bad);

        case (state_q)
            ST_TEST_SH: begin
                if (hdr_eval) begin
                    if (!lock_q) begin
                        if (hdr_bad) begin
                            slip_d   = 1'b1;
                            sh_cnt_d = '0;
                            wait_d   = '0;
                            state_d  = ST_SLIP_WAIT;
                        end else if (sh_nxt == SH_W'(LOCK_COUNT)) begin
                            lock_d   = 1'b1;
                            sh_cnt_d = '0;
                        end else begin
                            sh_cnt_d = sh_nxt;
                        end
                    end else begin
                        // Lock loss takes priority over window completion.
                        if (invld_nxt == BAD_W'(BAD_LOCK_COUNT)) begin
                            lock_d   = 1'b0;
                            slip_d   = 1'b1;
                            sh_cnt_d = '0;
                            invld_d  = '0;
                            wait_d   = '0;
                            state_d  = ST_SLIP_WAIT;
                        end else if (sh_nxt == SH_W'(LOCK_COUNT)) begin
                            sh_cnt_d = '0;
                            invld_d  = '0;
                        end else begin
                            sh_cnt_d = sh_nxt;
                            invld_d  = invld_nxt;
                        end
                    end
                end
            end
            ST_SLIP_WAIT: begin
                // The slip-pulse cycle is the first of the settle cycles.
                if (wait_q == WAIT_W'(SLIP_WAIT_CYCLES - 1)) begin
                    wait_d  = '0;
                    state_d = ST_TEST_SH;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = ST_TEST_SH;
            end
        endcase

        // BER monitor runs only while lock is held on both sides of the edge.
        if (lock_q && lock_d) begin
            if (timer_q == TMR_W'(BER_WINDOW - 1)) begin
                timer_d   = '0;
                hi_ber_d  = (ber_cnt_q >= BER_W'(BER_THRESH));
                ber_cnt_d = BER_W'(bad_eval);
            end else begin
                timer_d = timer_q + TMR_W'(1);
                if (bad_eval && (ber_cnt_q != BER_W'(BER_THRESH))) begin
                    ber_cnt_d = ber_cnt_q + BER_W'(1);
                end
            end
            if (ber_cnt_d >= BER_W'(BER_THRESH)) begin
                hi_ber_d = 1'b1;
            end
        end else begin
            timer_d   = '0;
            ber_cnt_d = '0;
            hi_ber_d  = 1'b0;
        end

        // Errored-block counter saturates; clear beats increment.
        if (i_clear_cnt) begin
            err_d = '0;
        end else if (lock_q && bad_eval && (err_q != {ERR_CNT_WIDTH{1'b1}})) begin
            err_d = err_q + ERR_CNT_WIDTH'(1);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= ST_TEST_SH;
            lock_q    <= 1'b0;
            slip_q    <= 1'b0;
            hi_ber_q  <= 1'b0;
            sh_cnt_q  <= '0;
            invld_q   <= '0;
            wait_q    <= '0;
            timer_q   <= '0;
            ber_cnt_q <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            lock_q    <= lock_d;
            slip_q    <= slip_d;
            hi_ber_q  <= hi_ber_d;
            sh_cnt_q  <= sh_cnt_d;
            invld_q   <= invld_d;
            wait_q    <= wait_d;
            timer_q   <= timer_d;
            ber_cnt_q <= ber_cnt_d;
            err_q     <= err_d;
        end
    end

    assign o_slip           = slip_q;
    assign o_block_lock     = lock_q;
    assign o_hi_ber         = hi_ber_q;
    assign o_errored_blocks = err_q;

endmodule

// File: tb/tb_pcs_rx_sync_monitor.sv
// tb_pcs_rx_sync_monitor
// Directed scenarios plus randomized header streams, checked every cycle
// against a timestamp-based reference model of the lock/BER/counter rules.
module tb_pcs_rx_sync_monitor;

  localparam int LC  = 16;
  localparam int BLC = 6;
  localparam int SW  = 8;
  localparam int BW  = 100;
  localparam int BT  = 5;
  localparam int EW  = 4;
  localparam int ERR_MAX = (1 << EW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          hv  = 1'b0;
  logic          clr = 1'b0;
  logic [1:0]    hdr = 2'b00;
  logic          slip;
  logic          lock;
  logic          hi_ber;
  logic [EW-1:0] err_cnt;

  pcs_rx_sync_monitor #(
    .LOCK_COUNT       (LC),
    .BAD_LOCK_COUNT   (BLC),
    .SLIP_WAIT_CYCLES (SW),
    .BER_WINDOW       (BW),
    .BER_THRESH       (BT),
    .ERR_CNT_WIDTH    (EW)
  ) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_header         (hdr),
    .i_header_valid   (hv),
    .i_clear_cnt      (clr),
    .o_slip           (slip),
    .o_block_lock     (lock),
    .o_hi_ber         (hi_ber),
    .o_errored_blocks (err_cnt)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Edge index m_n; settle window and BER window position are derived from
  // stored edge timestamps rather than down/up counters.
  int m_n = 0;
  int m_lock = 0, m_slip = 0, m_hi = 0, m_err = 0;
  int m_good = 0, m_wait_end = -1;
  int m_win_h = 0, m_win_b = 0;
  int m_lock_start = 0, m_ber_bad = 0;

  task automatic model_edge(input logic r, input logic v, input logic [1:0] h, input logic c);
    bit ev, bad, was_lock;
    if (r) begin
      m_lock = 0; m_slip = 0; m_hi = 0; m_err = 0;
      m_good = 0; m_wait_end = -1; m_win_h = 0; m_win_b = 0; m_ber_bad = 0;
    end else begin
      ev = v && (m_n > m_wait_end);
      bad = (h == 2'b00) || (h == 2'b11);
      was_lock = (m_lock != 0);
      m_slip = 0;
      if (!was_lock) begin
        if (ev) begin
          if (bad) begin
            m_slip = 1; m_good = 0; m_wait_end = m_n + SW;
          end else begin
            m_good++;
            if (m_good == LC) begin
              m_lock = 1; m_good = 0; m_win_h = 0; m_win_b = 0;
              m_lock_start = m_n + 1; m_ber_bad = 0; m_hi = 0;
            end
          end
        end
      end else begin
        if (ev) begin
          m_win_h++;
          if (bad) m_win_b++;
        end
        if (m_win_b == BLC) begin
          m_lock = 0; m_slip = 1; m_win_h = 0; m_win_b = 0;
          m_wait_end = m_n + SW; m_ber_bad = 0; m_hi = 0;
        end else begin
          if (m_win_h == LC) begin
            m_win_h = 0; m_win_b = 0;
          end
          if (((m_n - m_lock_start) % BW) == BW - 1) begin
            if (m_ber_bad < BT) m_hi = 0;
            m_ber_bad = (ev && bad) ? 1 : 0;
          end else if (ev && bad) begin
            m_ber_bad++;
          end
          if (m_ber_bad >= BT) m_hi = 1;
        end
      end
      if (was_lock && ev && bad && m_err < ERR_MAX) m_err++;
      if (c) m_err = 0;
    end
    m_n++;
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic v, input logic [1:0] h, input logic c);
    rst = r; hv = v; hdr = h; clr = c;
    @(posedge clk);
    model_edge(r, v, h, c);
    #1;
    check("lock",   32'(lock),    32'(m_lock));
    check("slip",   32'(slip),    32'(m_slip));
    check("hi_ber", 32'(hi_ber),  32'(m_hi));
    check("errcnt", 32'(err_cnt), 32'(m_err));
  endtask

  function automatic logic [1:0] good_hdr();
    return ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] bad_hdr();
    return ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
  endfunction

  task automatic good_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, good_hdr(), 1'b0);
  endtask

  task automatic bad_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, bad_hdr(), 1'b0);
  endtask

  int permille[7] = '{0, 20, 60, 100, 0, 120, 0};

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'b00, 1'b0);
    check("rst_lock", 32'(lock), 32'd0);
    check("rst_slip", 32'(slip), 32'd0);
    check("rst_err",  32'(err_cnt), 32'd0);

    // Acquisition: lock one cycle after the LC-th valid header
    good_n(LC - 1);
    check("acq_early", 32'(lock), 32'd0);
    good_n(1);
    check("acq_lock", 32'(lock), 32'd1);
    check("acq_noslip", 32'(slip), 32'd0);

    // Unlocked error: slip one cycle, settle headers ignored, full re-acquire
    step(1'b1, 1'b0, 2'b00, 1'b0);
    good_n(10);
    step(1'b0, 1'b1, 2'b11, 1'b0);
    check("unl_slip", 32'(slip), 32'd1);
    good_n(1);
    check("unl_slip_end", 32'(slip), 32'd0);
    good_n(SW - 1 + LC - 1);
    check("unl_no_early", 32'(lock), 32'd0);
    good_n(1);
    check("unl_relock", 32'(lock), 32'd1);

    // Lock retention, hi_ber set right after BT-th bad, then lock loss
    bad_n(BT);
    check("ber_hi", 32'(hi_ber), 32'd1);
    good_n(LC - BT);
    check("ret_lock", 32'(lock), 32'd1);
    bad_n(BLC);
    check("loss_lock", 32'(lock), 32'd0);
    check("loss_slip", 32'(slip), 32'd1);
    check("loss_hi", 32'(hi_ber), 32'd0);
    check("loss_err", 32'(err_cnt), 32'(BT + BLC));

    // Counter saturation, then clear wins over a same-cycle increment
    good_n(SW + LC);
    bad_n(BT);
    good_n(LC - BT);
    bad_n(4);
    check("err_sat", 32'(err_cnt), 32'(ERR_MAX));
    step(1'b0, 1'b1, 2'b11, 1'b1);
    check("err_clr", 32'(err_cnt), 32'd0);

    // Error-free window clears hi_ber at the wrap
    good_n(2 * BW);
    check("ber_clear", 32'(hi_ber), 32'd0);
    check("ber_lock", 32'(lock), 32'd1);

    // Reset mid-settle: re-acquire without waiting out the settle time
    step(1'b1, 1'b0, 2'b00, 1'b0);
    bad_n(1);
    good_n(5);
    step(1'b1, 1'b0, 2'b00, 1'b0);
    check("mid_rst_slip", 32'(slip), 32'd0);
    check("mid_rst_lock", 32'(lock), 32'd0);
    good_n(LC);
    check("mid_rst_relock", 32'(lock), 32'd1);

    // Randomized streams at several error densities
    foreach (permille[p]) begin
      for (int i = 0; i < 700; i++) begin
        logic r, v, c;
        logic [1:0] h;
        r = ($urandom_range(0, 999) == 0);
        v = ($urandom_range(0, 99) < 85);
        c = ($urandom_range(0, 199) == 0);
        h = ($urandom_range(0, 999) < permille[p]) ? bad_hdr() : good_hdr();
        step(r, v, h, c);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
